// File: rtl/window_stats.sv
// Order-statistics producer: ranks one serial 5x5 window, emits 3x3/5x5 min/med/max + centre.
// Latency: out_valid rises 26 cycles after the last input beat (25 rank cycles + 1).
// Backpressure: in_ready only in LOAD; results held in DONE until out_ready, no overlap.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_data   sample stream, raster order p=0..24
//   out_valid/out_ready         one result set per window
//   min3/med3/max3              inner 3x3 statistics (rows/cols 1..3)
//   min5/med5/max5              full 5x5 statistics
//   wCenter                     sample p=12
module window_stats #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] min3,
  output logic [DATA_WIDTH-1:0] med3,
  output logic [DATA_WIDTH-1:0] max3,
  output logic [DATA_WIDTH-1:0] min5,
  output logic [DATA_WIDTH-1:0] med5,
  output logic [DATA_WIDTH-1:0] max5,
  output logic [DATA_WIDTH-1:0] wCenter
);

  // Bit p set when raster position p lies in the inner 3x3 (p = 6..8, 11..13, 16..18).
  localparam logic [24:0] INNER = 25'h0739C0;
  localparam logic [4:0]  LAST  = 5'd24;
  localparam logic [4:0]  FIRST_INNER = 5'd6;

  typedef enum logic [1:0] {LOAD, RANK, DONE} state_t;

  state_t                state, state_nxt;
  logic [4:0]            cnt;
  logic [DATA_WIDTH-1:0] store [25];

  logic [DATA_WIDTH-1:0] run_min5, run_max5, run_min3, run_max3;
  logic [DATA_WIDTH-1:0] run_med5, run_med3;

  logic                  beat;
  logic                  inner_p;
  logic [DATA_WIDTH-1:0] cand;
  logic [4:0]            less5, eq5, less3, eq3;
  logic                  hit5, hit3;
  logic [DATA_WIDTH-1:0] med5_nxt, med3_nxt;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST) state_nxt = RANK;
      end
      RANK: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign beat    = in_valid && in_ready;
  assign inner_p = INNER[cnt];

  // ---------------- Ranking of candidate store[cnt] ----------------
  assign cand = store[cnt];

  always_comb begin
    less5 = '0;
    eq5   = '0;
    less3 = '0;
    eq3   = '0;
    for (int k = 0; k < 25; k++) begin
      if (store[k] < cand) begin
        less5 = less5 + 5'd1;
        if (INNER[k]) less3 = less3 + 5'd1;
      end else if (store[k] == cand) begin
        eq5 = eq5 + 5'd1;
        if (INNER[k]) eq3 = eq3 + 5'd1;
      end
    end
  end

  // Candidate is a median when it covers rank 12 (of 25) / rank 4 (of 9).
  assign hit5 = (less5 <= 5'd12) && (({1'b0, less5} + {1'b0, eq5}) > 6'd12);
  assign hit3 = inner_p && (less3 <= 5'd4) && (({1'b0, less3} + {1'b0, eq3}) > 6'd4);

  // The final candidate's result must reach the output copy in the same cycle.
  assign med5_nxt = hit5 ? cand : run_med5;
  assign med3_nxt = hit3 ? cand : run_med3;

  // ---------------- Sample store (contents don't-care after reset) ----------------
  always_ff @(posedge clk) begin
    if (state == LOAD && beat) store[cnt] <= in_data;
  end

  // ---------------- Counter, running stats, output registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      run_min5 <= '0;
      run_max5 <= '0;
      run_min3 <= '0;
      run_max3 <= '0;
      run_med5 <= '0;
      run_med3 <= '0;
      min3     <= '0;
      med3     <= '0;
      max3     <= '0;
      min5     <= '0;
      med5     <= '0;
      max5     <= '0;
      wCenter  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (beat) begin
            cnt <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
            if (cnt == 5'd0) begin
              run_min5 <= in_data;
              run_max5 <= in_data;
            end else begin
              if (in_data < run_min5) run_min5 <= in_data;
              if (in_data > run_max5) run_max5 <= in_data;
            end
            if (cnt == FIRST_INNER) begin
              run_min3 <= in_data;
              run_max3 <= in_data;
            end else if (inner_p) begin
              if (in_data < run_min3) run_min3 <= in_data;
              if (in_data > run_max3) run_max3 <= in_data;
            end
          end
        end
        RANK: begin
          cnt      <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
          run_med5 <= med5_nxt;
          run_med3 <= med3_nxt;
          if (cnt == LAST) begin
            min5    <= run_min5;
            med5    <= med5_nxt;
            max5    <= run_max5;
            min3    <= run_min3;
            med3    <= med3_nxt;
            max3    <= run_max3;
            wCenter <= store[12];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/window_stats.md
Name: window_stats

Overview:
- Producer side of the adaptive median selector: builds the order statistics that the selector consumes.
- Accepts one 5x5 pixel window as a serial stream of 25 samples over a valid/ready handshake.
- Ranks the samples sequentially and presents min/med/max for the inner 3x3 window, min/med/max for the full 5x5 window, and the centre pixel.
- Results go out on a valid/ready handshake, one result set per window.

Parameters:
- DATA_WIDTH, 8, pixel width in bits; all data ports and comparisons use this width.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data carries a window sample
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  DATA_WIDTH  window sample, raster order p=0..24 (row r=p/5, col c=p%5)
- out_valid  output  1  result set valid
- out_ready  input  1  downstream accepts result set
- min3, med3, max3  output  DATA_WIDTH each  inner 3x3 statistics (r,c in 1..3)
- min5, med5, max5  output  DATA_WIDTH each  5x5 statistics
- wCenter  output  DATA_WIDTH  sample p=12

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0:
  - state=LOAD; sample counter=0; rank index=0.
  - in_ready=1 after release; out_valid=0.
  - All result outputs = 0; sample store contents are don't-care.
- Beat definition: a beat transfers only when in_valid && in_ready; cycles with in_valid=0 do not advance the counter. All comparisons are unsigned.
- FSM LOAD:
  - in_ready=1; each beat writes in_data to store[cnt], then cnt++.
  - Running min5/max5 are updated on every beat; running min3/max3 only on inner-window beats.
  - The first beat (and first inner beat) initialises its running min and max.
  - On the 25th beat: cnt->0, go to RANK.
- FSM RANK:
  - in_ready=0; 25 cycles, candidate j=0..24, one per cycle.
  - Compare store[j] against all 25 samples in parallel: less5 = count(store[k]<store[j]), eq5 = count(store[k]==store[j]).
  - If less5<=12 && less5+eq5>12, the working med5 is set to store[j].
  - If j is inner: less3/eq3 are counted over the 9 inner samples only; if less3<=4 && less3+eq3>4, the working med3 is set to store[j].
  - Ties are harmless: every matching candidate has the same value.
  - After j=24: go to DONE.
- Output update on entry to DONE: working min/med/max and store[12] are copied to the output registers together.
- FSM DONE:
  - out_valid=1; in_ready=0.
  - Outputs are held stable while out_ready=0.
  - On out_valid && out_ready: out_valid=0, go to LOAD; in_ready=1 in the next cycle.
- Output retention: output registers keep their last values after the handshake until the next DONE entry.
- Latency: last input beat accepted in cycle T; RANK covers T+1..T+25; out_valid=1 from T+26.
- Minimum period: 51 cycles per window (25 load + 25 rank + 1 done).
- No overlap: input and output phases never overlap; in_ready=0 throughout RANK and DONE.
- Reset mid-operation: any partial window or pending result is discarded. After release the next 25 beats form a fresh window, with no residue from old min/max.
- out_ready asserted outside DONE: ignored.
- Width rule: less/eq counters are 5 bits (max 25); no arithmetic on pixel data, so no overflow or saturation is possible.

Test Plan:
- Ascending window, sample p = p (0..24) -> min5=0, med5=12, max5=24, min3=6, med3=12, max3=18, wCenter=12; out_valid exactly 26 cycles after the last beat.
- Descending window, sample p = 24-p -> identical outputs to the ascending case, demonstrating order independence.
- Impulse window: all 100, p=0 -> 0, p=12 -> 255 -> min5=0, med5=100, max5=255, min3=100, med3=100, max3=255, wCenter=255.
- Flat window, all 50 -> all seven outputs = 50 (heavy-tie case exercising median selection).
- Backpressure and gaps:
  - in_valid toggled 1/0 each cycle: only valid beats counted; latency is measured from the last beat.
  - In DONE, out_ready held 0 for 10 cycles: out_valid stays 1, outputs stable, in_ready=0.
  - Then out_ready=1: next window accepted and its results correct.
- Reset after 10 beats of an ascending window, then a full impulse window -> out_valid stays 0 until 26 cycles after the impulse window's last beat, with impulse results exact.
